// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one sdram_controller among NUM_PORTS clients.
// One transaction in flight at a time; completions are routed back to the owning port.
module sdram_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDRESS_WIDTH  = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int QUIESCE_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2*NUM_PORTS-1:0]             p_command,
  input  logic [ADDRESS_WIDTH*NUM_PORTS-1:0] p_address,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0]    p_write_data,
  output logic [NUM_PORTS-1:0]               p_ready,
  output logic [NUM_PORTS-1:0]               p_write_done,
  output logic [NUM_PORTS-1:0]               p_read_valid,
  output logic [DATA_WIDTH-1:0]              p_read_data,
  output logic [$clog2(NUM_PORTS)-1:0]       grant,
  output logic                               busy,
  output logic [1:0]                         command,
  output logic [ADDRESS_WIDTH-1:0]           data_address,
  output logic [DATA_WIDTH-1:0]              data_write,
  input  logic [DATA_WIDTH-1:0]              data_read,
  input  logic                               data_read_valid,
  input  logic                               data_write_done
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(QUIESCE_CYCLES + 1);

  localparam logic [1:0] QUIESCE   = 2'd0;
  localparam logic [1:0] ARB       = 2'd1;
  localparam logic [1:0] ISSUE     = 2'd2;
  localparam logic [1:0] READ_DATA = 2'd3;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  logic [1:0]               state;
  logic [PW-1:0]            pointer;
  logic [CW-1:0]            quiesce_count;

  logic                     found;
  logic [PW-1:0]            winner;
  logic [1:0]               winner_cmd;
  logic [ADDRESS_WIDTH-1:0] winner_addr;
  logic [DATA_WIDTH-1:0]    winner_data;
  int                       scan;

  assign busy = (state != ARB);

  // Scan upward from the pointer with wrap; command value 3 never qualifies.
  always_comb begin
    found       = 1'b0;
    winner      = pointer;
    winner_cmd  = CMD_IDLE;
    winner_addr = '0;
    winner_data = '0;
    scan        = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = int'(pointer) + i;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      if (!found && (p_command[2*scan +: 2] == CMD_WRITE ||
                     p_command[2*scan +: 2] == CMD_READ)) begin
        found       = 1'b1;
        winner      = PW'(scan);
        winner_cmd  = p_command[2*scan +: 2];
        winner_addr = p_address[ADDRESS_WIDTH*scan +: ADDRESS_WIDTH];
        winner_data = p_write_data[DATA_WIDTH*scan +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= QUIESCE;
      pointer       <= '0;
      quiesce_count <= CW'(QUIESCE_CYCLES);
      grant         <= '0;
      command       <= CMD_IDLE;
      data_address  <= '0;
      data_write    <= '0;
      p_ready       <= '0;
      p_write_done  <= '0;
      p_read_valid  <= '0;
      p_read_data   <= '0;
    end else begin
      p_ready      <= '0;
      p_write_done <= '0;
      p_read_valid <= '0;
      case (state)
        // The controller is not reset, so wait until it has been silent long enough.
        QUIESCE: begin
          if (data_read_valid || data_write_done) begin
            quiesce_count <= CW'(QUIESCE_CYCLES);
          end else if (quiesce_count == '0) begin
            state <= ARB;
          end else begin
            quiesce_count <= quiesce_count - 1'b1;
          end
        end
        ARB: begin
          if (found) begin
            grant           <= winner;
            command         <= winner_cmd;
            data_address    <= winner_addr;
            data_write      <= winner_data;
            p_ready[winner] <= 1'b1;
            pointer         <= (int'(winner) == NUM_PORTS - 1) ? '0 : winner + 1'b1;
            state           <= ISSUE;
          end
        end
        // Command stays asserted until completion so refresh stalls are absorbed.
        ISSUE: begin
          if (command == CMD_WRITE && data_write_done) begin
            command             <= CMD_IDLE;
            p_write_done[grant] <= 1'b1;
            state               <= ARB;
          end else if (command == CMD_READ && data_read_valid) begin
            command             <= CMD_IDLE;
            p_read_valid[grant] <= 1'b1;
            p_read_data         <= data_read;
            state               <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (data_read_valid) begin
            p_read_valid[grant] <= 1'b1;
            p_read_data         <= data_read;
          end else begin
            state <= ARB;
          end
        end
        default: state <= QUIESCE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: a behavioural controller model checks issued commands and
// queues the completions each port must see; a monitor pops them off.
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int QC = 64;
  localparam int Q2 = 8;

  typedef struct { int port; logic [1:0] cmd; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
  typedef struct { int port; logic [DW-1:0] data; int cyc; } beat_t;
  typedef struct { int port; int cyc; } done_t;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]     req_cmd   [NP];
  logic [AW-1:0]  req_addr  [NP];
  logic [DW-1:0]  req_wdata [NP];
  logic [2*NP-1:0]  p_command;
  logic [AW*NP-1:0] p_address;
  logic [DW*NP-1:0] p_write_data;
  logic [NP-1:0]    p_ready, p_write_done, p_read_valid;
  logic [DW-1:0]    p_read_data;
  logic [1:0]       grant;
  logic             busy;
  logic [1:0]       command;
  logic [AW-1:0]    data_address;
  logic [DW-1:0]    data_write;
  logic [DW-1:0]    ctl_read_data;
  logic             ctl_read_valid, ctl_write_done;

  logic [3:0]  cmd2;
  logic [47:0] addr2;
  logic [63:0] wdata2;
  logic [1:0]  p_ready2, p_write_done2, p_read_valid2;
  logic [31:0] p_read_data2, data_write2, rd_data2;
  logic        grant2, busy2, rd_valid2, wr_done2;
  logic [1:0]  command2;
  logic [23:0] data_address2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cycles = 0;
  int burst_len = 4;
  int drop_from_beat = 99;
  int model_beat = 0;
  int last_strobe_cyc = 0;
  logic model_busy = 1'b0;
  logic [DW-1:0] read_base = 16'h00A0;

  txn_t  issued_q[$];
  beat_t rd_q[$];
  done_t wd_q[$];
  int    ready_log[$];

  always #5 clk = ~clk;

  always_comb begin
    p_command    = '0;
    p_address    = '0;
    p_write_data = '0;
    for (int i = 0; i < NP; i++) begin
      p_command[2*i +: 2]     = req_cmd[i];
      p_address[AW*i +: AW]   = req_addr[i];
      p_write_data[DW*i +: DW] = req_wdata[i];
    end
  end

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .QUIESCE_CYCLES(QC)) dut (
    .clk(clk), .reset(reset), .p_command(p_command), .p_address(p_address),
    .p_write_data(p_write_data), .p_ready(p_ready), .p_write_done(p_write_done),
    .p_read_valid(p_read_valid), .p_read_data(p_read_data), .grant(grant), .busy(busy),
    .command(command), .data_address(data_address), .data_write(data_write),
    .data_read(ctl_read_data), .data_read_valid(ctl_read_valid), .data_write_done(ctl_write_done)
  );

  sdram_port_arbiter #(.NUM_PORTS(2), .ADDRESS_WIDTH(24), .DATA_WIDTH(32), .QUIESCE_CYCLES(Q2)) dut2 (
    .clk(clk), .reset(reset), .p_command(cmd2), .p_address(addr2),
    .p_write_data(wdata2), .p_ready(p_ready2), .p_write_done(p_write_done2),
    .p_read_valid(p_read_valid2), .p_read_data(p_read_data2), .grant(grant2), .busy(busy2),
    .command(command2), .data_address(data_address2), .data_write(data_write2),
    .data_read(rd_data2), .data_read_valid(rd_valid2), .data_write_done(wr_done2)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller model: accepts one command, optionally stalls, then strobes completion.
  initial begin : controller_model
    txn_t t;
    logic [DW-1:0] d;
    ctl_read_valid = 1'b0;
    ctl_write_done = 1'b0;
    ctl_read_data  = '0;
    forever begin
      @(negedge clk);
      if (command != 2'd0) begin
        model_busy = 1'b1;
        #1;
        checks++;
        if (issued_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unrequested_command: got cmd=%0d addr=%h, required no command", command, data_address);
          t = '{-1, command, data_address, data_write};
        end else begin
          t = issued_q.pop_front();
          if (command !== t.cmd || data_address !== t.addr || data_write !== t.wdata) begin
            errors++;
            $display("[TB] FAIL issued_command: got %0d/%h/%h, required %0d/%h/%h",
                     command, data_address, data_write, t.cmd, t.addr, t.wdata);
          end
        end
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          checks++;
          if (command !== t.cmd || data_address !== t.addr || data_write !== t.wdata) begin
            errors++;
            $display("[TB] FAIL command_hold: stall %0d got %0d/%h/%h, required %0d/%h/%h",
                     s, command, data_address, data_write, t.cmd, t.addr, t.wdata);
          end
        end
        if (t.cmd == 2'd1) begin
          ctl_write_done  = 1'b1;
          last_strobe_cyc = cyc + 1;
          wd_q.push_back('{t.port, cyc + 1});
          @(negedge clk);
          ctl_write_done = 1'b0;
          checks++;
          if (command !== 2'd0) begin
            errors++;
            $display("[TB] FAIL write_cmd_drop: got %0d, required 0", command);
          end
        end else begin
          for (int b = 0; b < burst_len; b++) begin
            d = DW'(read_base + {8'h00, t.addr[7:0]} + DW'(b));
            ctl_read_valid  = 1'b1;
            ctl_read_data   = d;
            model_beat      = b;
            last_strobe_cyc = cyc + 1;
            if (b < drop_from_beat) rd_q.push_back('{t.port, d, cyc + 1});
            @(negedge clk);
            if (b == 0) begin
              checks++;
              if (command !== 2'd0) begin
                errors++;
                $display("[TB] FAIL read_cmd_drop: got %0d, required 0", command);
              end
            end
          end
          ctl_read_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: every forwarded strobe must match the head of its scoreboard queue.
  initial begin : monitor
    beat_t eb;
    done_t ed;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) if (p_ready[i]) ready_log.push_back(i);
      if (p_read_valid != '0) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stray_read_valid: got %b data %h, required 0", p_read_valid, p_read_data);
        end else begin
          eb = rd_q.pop_front();
          if (p_read_valid !== NP'(1 << eb.port) || p_read_data !== eb.data || cyc != eb.cyc) begin
            errors++;
            $display("[TB] FAIL read_beat: got valid=%b data=%h cyc=%0d, required valid=%b data=%h cyc=%0d",
                     p_read_valid, p_read_data, cyc, NP'(1 << eb.port), eb.data, eb.cyc);
          end
        end
      end
      if (p_write_done != '0) begin
        checks++;
        if (wd_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stray_write_done: got %b, required 0", p_write_done);
        end else begin
          ed = wd_q.pop_front();
          if (p_write_done !== NP'(1 << ed.port) || cyc != ed.cyc) begin
            errors++;
            $display("[TB] FAIL write_done: got %b cyc=%0d, required %b cyc=%0d",
                     p_write_done, cyc, NP'(1 << ed.port), ed.cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_request(input int port, input logic [1:0] cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int limit, output int lat);
    req_cmd[port]   = cmd;
    req_addr[port]  = addr;
    req_wdata[port] = wd;
    lat = 0;
    while (lat < limit) begin
      @(negedge clk);
      lat++;
      if (p_ready[port] === 1'b1) break;
    end
    if (p_ready[port] === 1'b1) begin
      issued_q.push_back('{port, cmd, addr, wd});
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: port %0d got no p_ready in %0d cycles, required p_ready", port, limit);
    end
    req_cmd[port]   = 2'd0;
    req_addr[port]  = ~addr;
    req_wdata[port] = ~wd;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(model_busy == 1'b0 && busy === 1'b0 && rd_q.size() == 0 && wd_q.size() == 0) && n < limit);
    if (n >= limit) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got busy=%b model_busy=%b, required idle", busy, model_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({command, data_address, data_write} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctl_side: got %0d/%h/%h, required 0/0/0", command, data_address, data_write);
    end
    checks++;
    if ({p_ready, p_write_done, p_read_valid, p_read_data, grant} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_port_side: got %b/%b/%b/%h/%0d, required all 0",
               p_ready, p_write_done, p_read_valid, p_read_data, grant);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_path();
    int lat;
    wait_idle(QC + 20);
    stall_cycles = 3;
    do_request(1, 2'd1, 24'h012345, 16'hBEEF, 20, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("[TB] FAIL write_ready_latency: got %0d, required 1", lat);
    end
    @(negedge clk);
    checks++;
    if (p_ready !== 4'b0000 || busy !== 1'b1 || grant !== 2'd1) begin
      errors++;
      $display("[TB] FAIL write_in_flight: got ready=%b busy=%b grant=%0d, required 0000/1/1", p_ready, busy, grant);
    end
    wait_idle(50);
    checks++;
    if (grant !== 2'd1 || command !== 2'd0) begin
      errors++;
      $display("[TB] FAIL write_after: got grant=%0d cmd=%0d, required 1/0", grant, command);
    end
  endtask

  task automatic test_read_path();
    int lat;
    stall_cycles = 0;
    do_request(2, 2'd2, 24'h000100, 16'h0000, 20, lat);
    wait_idle(50);
  endtask

  task automatic test_ignored_and_stall();
    int lat;
    logic saw;
    saw = 1'b0;
    req_cmd[0] = 2'd3;
    repeat (10) begin
      @(negedge clk);
      if (p_ready != '0) saw = 1'b1;
    end
    req_cmd[0] = 2'd0;
    checks++;
    if (saw) begin
      errors++;
      $display("[TB] FAIL ignored_command: got p_ready, required none for command 3");
    end
    stall_cycles = 10;
    do_request(0, 2'd2, 24'h000040, 16'h5555, 20, lat);
    wait_idle(60);
    stall_cycles = 0;
  endtask

  task automatic test_fairness();
    int lat;
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};
    do_request(3, 2'd1, 24'h000300, 16'h3333, 20, lat);
    wait_idle(50);
    ready_log.delete();
    fork
      begin int l; do_request(0, 2'd2, 24'h000010, 16'h0000, 200, l); do_request(0, 2'd2, 24'h000011, 16'h0000, 200, l); end
      begin int l; do_request(1, 2'd2, 24'h000020, 16'h0000, 200, l); do_request(1, 2'd2, 24'h000021, 16'h0000, 200, l); end
      begin int l; do_request(3, 2'd2, 24'h000030, 16'h0000, 200, l); do_request(3, 2'd2, 24'h000031, 16'h0000, 200, l); end
    join
    wait_idle(100);
    checks++;
    if (ready_log.size() != 6) begin
      errors++;
      $display("[TB] FAIL fairness_count: got %0d grants, required 6", ready_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ready_log[i] != exp_order[i]) begin
          errors++;
          $display("[TB] FAIL fairness_order: grant %0d got port %0d, required port %0d", i, ready_log[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int lat;
    int n;
    stall_cycles   = 0;
    drop_from_beat = 2;
    do_request(2, 2'd2, 24'h000050, 16'h0000, 20, lat);
    n = 0;
    while (!(ctl_read_valid && model_beat == 2) && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (command !== 2'd0 || p_read_valid !== '0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_read: got cmd=%0d valid=%b busy=%b, required 0/0000/1", command, p_read_valid, busy);
    end
    @(negedge clk);
    #3;
    reset = 1'b0;
    drop_from_beat = 99;
    do_request(0, 2'd2, 24'h000060, 16'h0000, QC + 40, lat);
    checks++;
    if (cyc - last_strobe_cyc < QC + 1) begin
      errors++;
      $display("[TB] FAIL quiesce_after_reset: got grant %0d cycles after last strobe, required >= %0d",
               cyc - last_strobe_cyc, QC + 1);
    end
    wait_idle(60);
  endtask

  task automatic test_wide_write();
    int n;
    n = 0;
    while (busy2 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd2[1:0]    = 2'd1;
    addr2[23:0]  = 24'h000777;
    wdata2[31:0] = 32'hDEADBEEF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (p_ready2[0] !== 1'b1 && n < 20);
    checks++;
    if (p_ready2 !== 2'b01) begin
      errors++;
      $display("[TB] FAIL wide_ready: got %b, required 01", p_ready2);
    end
    cmd2[1:0]    = 2'd0;
    wdata2[31:0] = 32'h12345678;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (data_write2 !== 32'hDEADBEEF || command2 !== 2'd1 || data_address2 !== 24'h000777) begin
        errors++;
        $display("[TB] FAIL wide_hold: got %h/%0d/%h, required deadbeef/1/000777", data_write2, command2, data_address2);
      end
    end
    wr_done2 = 1'b1;
    @(negedge clk);
    wr_done2 = 1'b0;
    checks++;
    if (command2 !== 2'd0 || p_write_done2 !== 2'b01) begin
      errors++;
      $display("[TB] FAIL wide_done: got cmd=%0d done=%b, required 0/01", command2, p_write_done2);
    end
    @(negedge clk);
    checks++;
    if (p_write_done2 !== 2'b00 || busy2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wide_done_pulse: got done=%b busy=%b, required 00/0", p_write_done2, busy2);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NP; i++) begin
      req_cmd[i]   = 2'd0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    cmd2 = '0; addr2 = '0; wdata2 = '0;
    rd_data2 = '0; rd_valid2 = 1'b0; wr_done2 = 1'b0;

    test_reset();
    test_write_path();
    test_read_path();
    test_ignored_and_stall();
    test_fairness();
    test_reset_mid_read();
    test_wide_write();

    checks++;
    if (issued_q.size() != 0 || rd_q.size() != 0 || wd_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d/%0d left, required 0/0/0",
               issued_q.size(), rd_q.size(), wd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
